// File: rtl/thresholding_cfg_loader_if.sv
// Bundle of the threshold stream, datapath gating and core write-port signals.
// Pure wiring, no latency.
// The loader takes the slave view; the environment (DMA side / core) takes the master view.
interface thresholding_cfg_loader_if #(
  parameter int N = 4,
  parameter int M = 8,
  parameter int C = 1
);
  localparam int TDW = ((M + 7) / 8) * 8;
  localparam int AW  = $clog2(C) + N;

  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [TDW-1:0] s_axis_tdata;
  logic           s_axis_tlast;
  logic           dp_idle;
  logic           dp_hold;
  logic           twe;
  logic [AW-1:0]  twa;
  logic [M-1:0]   twd;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, dp_idle,
    input  s_axis_tready, dp_hold, twe, twa, twd
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, dp_idle,
    output s_axis_tready, dp_hold, twe, twa, twd
  );
endinterface

// File: rtl/thresholding_cfg_loader.sv
// Streams a full threshold table into a thresholding core while the datapath is held off.
// Latency: handshake at t -> write at t+1; final handshake -> done/busy low at t+2.
// Backpressure: tready only in LOAD/SKIP; writes are never stalled (core takes one per cycle).
module thresholding_cfg_loader #(
  parameter int N = 4,
  parameter int M = 8,
  parameter int C = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  thresholding_cfg_loader_if.slave bus
);
  localparam int T   = 2**N - 1;
  localparam int W   = C * T;
  localparam int CW  = $clog2(C);
  localparam int CNW = (CW > 0) ? CW : 1;
  localparam int BW  = $clog2(W + 1);
  localparam int AW  = CW + N;

  localparam logic [N-1:0]  IDX_LAST  = N'(T - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(W - 1);

  typedef enum logic [2:0] {IDLE, HOLD, LOAD, SKIP, FIN} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    idx_q, idx_d;
  logic [CNW-1:0]  cnl_q, cnl_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            twe_q, twe_d;
  logic            rdy_q, rdy_d;
  logic            hold_q, hold_d;
  logic [AW-1:0]   twa_q, twa_d;
  logic [M-1:0]    twd_q, twd_d;
  logic            hs;
  logic [AW-1:0]   addr;

  assign hs = bus.s_axis_tvalid && rdy_q;
  // For C=1 the channel bit falls off the top, leaving twa = idx.
  assign addr = AW'({cnl_q, idx_q});

  // Next-state, counters and registered-output computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnl_d   = cnl_q;
    beat_d  = beat_q;
    err_d   = err_q;
    done_d  = 1'b0;
    twe_d   = 1'b0;
    twa_d   = twa_q;
    twd_d   = twd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HOLD;
          err_d   = 1'b0;
          idx_d   = '0;
          cnl_d   = '0;
          beat_d  = '0;
        end
      end
      HOLD: begin
        if (bus.dp_idle) state_d = LOAD;
      end
      LOAD: begin
        if (hs) begin
          twe_d  = 1'b1;
          twa_d  = addr;
          twd_d  = bus.s_axis_tdata[M-1:0];
          beat_d = beat_q + 1'b1;
          // Index 2^N-1 is never issued: wrap one early and step the channel.
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            cnl_d = cnl_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          if (beat_q == BEAT_LAST) begin
            if (bus.s_axis_tlast) begin
              state_d = FIN;
            end else begin
              err_d   = 1'b1;
              state_d = SKIP;
            end
          end else if (bus.s_axis_tlast) begin
            err_d   = 1'b1;
            state_d = FIN;
          end
        end
      end
      SKIP: begin
        if (hs && bus.s_axis_tlast) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Gating outputs follow the state being entered so they line up with it.
    rdy_d  = (state_d == LOAD) || (state_d == SKIP);
    hold_d = rdy_d || (state_d == HOLD);
  end

  // State and output registers; reset leaves the table as partially written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnl_q   <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      twe_q   <= 1'b0;
      rdy_q   <= 1'b0;
      hold_q  <= 1'b0;
      twa_q   <= '0;
      twd_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnl_q   <= cnl_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      done_q  <= done_d;
      twe_q   <= twe_d;
      rdy_q   <= rdy_d;
      hold_q  <= hold_d;
      twa_q   <= twa_d;
      twd_q   <= twd_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign done              = done_q;
  assign err               = err_q;
  assign bus.s_axis_tready = rdy_q;
  assign bus.dp_hold       = hold_q;
  assign bus.twe           = twe_q;
  assign bus.twa           = twa_q;
  assign bus.twd           = twd_q;
endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Directed bench for the threshold loader with N=2, M=8, C=2 (T=3, W=6).
// Writes and done pulses are recorded on the falling edge; checks run in one linear sequence.
module tb_thresholding_cfg_loader;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, err;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   last_hs = 0;
  int   wa_q[$];
  int   wd_q[$];
  int   wc_q[$];
  int   wh_q[$];
  int   exp_twa[6] = '{0, 1, 2, 4, 5, 6};

  thresholding_cfg_loader_if #(.N(2), .M(8), .C(2)) bus ();

  thresholding_cfg_loader #(.N(2), .M(8), .C(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after the k-th rising edge, cyc reads k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every write and done pulse mid-cycle.
  always @(negedge clk) begin
    if (bus.twe === 1'b1) begin
      wa_q.push_back(int'(bus.twa));
      wd_q.push_back(int'(bus.twd));
      wc_q.push_back(cyc);
      wh_q.push_back(int'(bus.dp_hold));
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    wh_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one beat; the handshake lands on the edge after a mid-cycle tready.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    while (!got && n < 50) begin
      @(negedge clk);
      if (bus.s_axis_tready === 1'b1) got = 1'b1;
      n = n + 1;
    end
    chk($sformatf("handshake_%0d", d), 32'(got), 32'd1);
    last_hs = cyc + 1;
    @(posedge clk); #1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n, input int base);
    chk({tag, "_wr_count"}, 32'(wa_q.size()), 32'(n));
    for (int i = 0; i < n && i < wa_q.size(); i++) begin
      chk($sformatf("%s_twa%0d", tag, i), 32'(wa_q[i]), 32'(exp_twa[i]));
      chk($sformatf("%s_twd%0d", tag, i), 32'(wd_q[i]), 32'(base + i));
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst               = 1'b1;
    start             = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.dp_idle       = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(bus.dp_hold), 32'd0);
    chk("rst_twe", 32'(bus.twe), 32'd0);
    chk("rst_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("rst_twa", 32'(bus.twa), 32'd0);
    chk("rst_twd", 32'(bus.twd), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full table: 10..15, tlast on the sixth word.
    clr();
    bus.dp_idle = 1'b1;
    pulse_start();
    chk("t1_busy_hold", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) send_beat(8'(10 + i), i == 5);
    settle();
    check_writes("t1", 6, 10);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_lat", 32'(done_cyc), 32'(last_hs + 1));
    chk("t1_last_wr_cyc", 32'(wc_q[5]), 32'(last_hs));
    chk("t1_hold_first_wr", 32'(wh_q[0]), 32'd1);
    chk("t1_hold_fin", 32'(wh_q[5]), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Early tlast on word 3.
    clr();
    pulse_start();
    for (int i = 0; i < 3; i++) send_beat(8'(50 + i), i == 2);
    settle();
    check_writes("t2", 3, 50);
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);
    chk("t2_done_lat", 32'(done_cyc), 32'(last_hs + 1));
    chk("t2_busy_end", 32'(busy), 32'd0);

    // Eight words, tlast on the eighth: last two are skipped.
    clr();
    pulse_start();
    for (int i = 0; i < 8; i++) send_beat(8'(40 + i), i == 7);
    settle();
    check_writes("t3", 6, 40);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_done_cnt", 32'(done_cnt), 32'd1);
    chk("t3_done_lat", 32'(done_cyc), 32'(last_hs + 1));

    // Datapath busy: loader must wait in HOLD.
    clr();
    bus.dp_idle = 1'b0;
    pulse_start();
    chk("t4_err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t4_hold_%0d", i), 32'(bus.dp_hold), 32'd1);
      chk($sformatf("t4_tready_%0d", i), 32'(bus.s_axis_tready), 32'd0);
    end
    chk("t4_no_writes", 32'(wa_q.size()), 32'd0);
    @(posedge clk); #1;
    bus.dp_idle = 1'b1;
    @(posedge clk); #1;
    chk("t4_tready_rise", 32'(bus.s_axis_tready), 32'd1);
    for (int i = 0; i < 6; i++) send_beat(8'(60 + i), i == 5);
    settle();
    check_writes("t4", 6, 60);
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset after two writes, then a clean reload.
    clr();
    pulse_start();
    send_beat(8'd20, 1'b0);
    send_beat(8'd21, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_wr_before_rst", 32'(wa_q.size()), 32'd2);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_err", 32'(err), 32'd0);
    chk("t5_hold", 32'(bus.dp_hold), 32'd0);
    chk("t5_twe", 32'(bus.twe), 32'd0);
    chk("t5_tready", 32'(bus.s_axis_tready), 32'd0);
    chk("t5_twa", 32'(bus.twa), 32'd0);
    chk("t5_twd", 32'(bus.twd), 32'd0);
    #3;
    rst = 1'b0;
    settle();
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    clr();
    pulse_start();
    for (int i = 0; i < 6; i++) send_beat(8'(70 + i), i == 5);
    settle();
    check_writes("t5_reload", 6, 70);
    chk("t5_reload_done", 32'(done_cnt), 32'd1);
    chk("t5_reload_err", 32'(err), 32'd0);

    // start pulsed mid-load is ignored.
    clr();
    pulse_start();
    for (int i = 0; i < 3; i++) send_beat(8'(30 + i), 1'b0);
    pulse_start();
    for (int i = 3; i < 6; i++) send_beat(8'(30 + i), i == 5);
    settle();
    settle();
    check_writes("t6", 6, 30);
    chk("t6_done_cnt", 32'(done_cnt), 32'd1);
    chk("t6_busy_end", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
